// File: rtl/aes_key_reverse_256_if.sv
// Handshake/bus bundle for aes_key_reverse_256; subkey_ready exists only when
// AES_KEYREV_STALL_EN is defined.
interface aes_key_reverse_256_if;
  logic         start;
  logic [255:0] last_key;
  logic [127:0] subkey;
  logic [3:0]   round;
  logic         subkey_valid;
  logic         busy;
  logic         done;
`ifdef AES_KEYREV_STALL_EN
  logic         subkey_ready;

  modport master (
    output start, last_key, subkey_ready,
    input  subkey, round, subkey_valid, busy, done
  );
  modport slave (
    input  start, last_key, subkey_ready,
    output subkey, round, subkey_valid, busy, done
  );
`else
  modport master (
    output start, last_key,
    input  subkey, round, subkey_valid, busy, done
  );
  modport slave (
    input  start, last_key,
    output subkey, round, subkey_valid, busy, done
  );
`endif
endinterface

// File: rtl/aes_key_reverse_256.sv
// Inverse AES-256 key schedule: emits round keys 14..0 from {rk13, rk14}.
// Optional consumer back-pressure via AES_KEYREV_STALL_EN (adds subkey_ready).
module aes_key_reverse_256 #(
  parameter int unsigned NR = 14,
  parameter int unsigned NK = 8
) (
  input logic                  clk,
  input logic                  reset,
  aes_key_reverse_256_if.slave kif
);

  localparam int unsigned    WW      = NK * 32;
  localparam logic [3:0]     LAST_RD = 4'(NR);

  typedef enum logic {IDLE, EMIT} state_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Forward S-box as GF(2^8) inverse (x^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv;
    logic [7:0] sq;
    inv = 8'h01;
    sq  = a;
    for (int unsigned i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  state_t         state_q, state_d;
  logic [WW-1:0]  win_q, win_d;
  logic [127:0]   subkey_q, subkey_d;
  logic [3:0]     round_q, round_d;
  logic           valid_q, valid_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic [31:0]    wd [NK];
  logic [31:0]    x;
  logic [31:0]    sx;
  logic [7:0]     rcon;
  logic [127:0]   nw;
  logic           adv;

  // Window holds w[k..k+7]; an odd current round means the next key's
  // j=k+4 lands on j%8==0 (RotWord + Rcon), otherwise plain SubWord.
  always_comb begin
    for (int unsigned i = 0; i < NK; i++) wd[i] = win_q[WW-1-32*i -: 32];
    rcon = 8'h01 << round_q[3:1];
    x    = round_q[0] ? {wd[3][23:0], wd[3][31:24]} : wd[3];
    sx   = {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    if (round_q[0]) sx[31:24] = sx[31:24] ^ rcon;
    nw   = {wd[4] ^ sx, wd[5] ^ wd[4], wd[6] ^ wd[5], wd[7] ^ wd[6]};
  end

`ifdef AES_KEYREV_STALL_EN
  assign adv = kif.subkey_ready;
`else
  assign adv = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    subkey_d = subkey_q;
    round_d  = round_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    done_d   = done_q;
    unique case (state_q)
      IDLE: begin
        if (kif.start) begin
          state_d  = EMIT;
          win_d    = kif.last_key;
          subkey_d = kif.last_key[127:0];
          round_d  = LAST_RD;
          valid_d  = 1'b1;
          busy_d   = 1'b1;
          done_d   = 1'b0;
        end
      end
      EMIT: begin
        if (adv) begin
          if (round_q == 4'd0) begin
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
          end else if (round_q == LAST_RD) begin
            subkey_d = win_q[WW-1 -: 128];
            round_d  = round_q - 4'd1;
          end else begin
            subkey_d = nw;
            round_d  = round_q - 4'd1;
            win_d    = {nw, win_q[WW-1 -: 128]};
            done_d   = (round_q == 4'd1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      win_q    <= '0;
      subkey_q <= '0;
      round_q  <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      subkey_q <= subkey_d;
      round_q  <= round_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign kif.subkey       = subkey_q;
  assign kif.round        = round_q;
  assign kif.subkey_valid = valid_q;
  assign kif.busy         = busy_q;
  assign kif.done         = done_q;

endmodule

// File: tb/tb_aes_key_reverse_256.sv
// Scoreboard bench for aes_key_reverse_256: a forward key-expansion model fills
// the expected queue on each start, a negedge monitor pops on every transfer.
module tb_aes_key_reverse_256;

  logic clk;
  logic reset;
  logic ready_drv;
  logic rdy;

  aes_key_reverse_256_if kif ();

  aes_key_reverse_256 dut (.clk(clk), .reset(reset), .kif(kif.slave));

`ifdef AES_KEYREV_STALL_EN
  assign kif.subkey_ready = ready_drv;
  assign rdy = ready_drv;
`else
  assign rdy = 1'b1;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   r;
    logic [127:0] k;
    logic         d;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   done_cnt = 0;

  localparam logic [127:0] RK14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;
  localparam logic [127:0] RK1  = 128'h101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] RK0  = 128'h000102030405060708090a0b0c0d0e0f;

  logic [7:0] sbt [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  logic [31:0] fw [60];

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbt[x[31:24]], sbt[x[23:16]], sbt[x[15:8]], sbt[x[7:0]]};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Forward expansion of the full key; fills fw[0..59].
  task automatic expand(input logic [255:0] key);
    logic [31:0] t;
    for (int i = 0; i < 8; i++) fw[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = fw[i-1];
      if (i % 8 == 0)      t = subw({t[23:0], t[31:24]}) ^ {8'h01 << (i/8 - 1), 24'h0};
      else if (i % 8 == 4) t = subw(t);
      fw[i] = fw[i-8] ^ t;
    end
  endtask

  task automatic push_seq(input logic [255:0] key, input bit hand, output logic [255:0] lk);
    exp_t e;
    expand(key);
    for (int i = 0; i < 8; i++) lk[255-32*i -: 32] = fw[52+i];
    for (int r = 14; r >= 0; r--) begin
      e.r = 4'(r);
      e.k = {fw[4*r], fw[4*r+1], fw[4*r+2], fw[4*r+3]};
      e.d = (r == 0);
      if (hand && r == 14) e.k = RK14;
      if (hand && r == 1)  e.k = RK1;
      if (hand && r == 0)  e.k = RK0;
      exp_q.push_back(e);
    end
  endtask

  task automatic issue(input logic [255:0] key, input bit hand);
    logic [255:0] lk;
    push_seq(key, hand, lk);
    kif.last_key = lk;
    kif.start    = 1'b1;
    @(posedge clk); #1;
    kif.start    = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((kif.busy || exp_q.size() != 0) && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    chk({tag, "_drain"}, 128'(exp_q.size()), 128'd0);
    chk({tag, "_idle"}, 128'(kif.busy), 128'd0);
  endtask

  task automatic wait_round(input logic [3:0] r, input string tag);
    int n;
    n = 0;
    while (!(kif.subkey_valid && kif.round == r) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_reach"}, 128'(n < 40), 128'd1);
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset && kif.subkey_valid && rdy) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_key: got round %0d with empty queue", kif.round);
      end else begin
        e = exp_q.pop_front();
        chk("round", 128'(kif.round), 128'(e.r));
        chk("subkey", kif.subkey, e.k);
        chk("done", 128'(kif.done), 128'(e.d));
        chk("busy_valid", 128'(kif.busy), 128'd1);
        if (kif.done) done_cnt++;
      end
    end else if (!reset && !kif.subkey_valid) begin
      chk("done_idle", 128'(kif.done), 128'd0);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] key;
    int idle_cnt;
    int d0;
    reset        = 1'b1;
    ready_drv    = 1'b1;
    kif.start    = 1'b0;
    kif.last_key = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_subkey", kif.subkey, 128'd0);
    chk("rst_round", 128'(kif.round), 128'd0);
    chk("rst_valid", 128'(kif.subkey_valid), 128'd0);
    chk("rst_busy", 128'(kif.busy), 128'd0);
    chk("rst_done", 128'(kif.done), 128'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // FIPS-197 256-bit key with hand-known rounds 14, 1, 0
    issue(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 1'b1);
    wait_idle("fips");

    for (int i = 0; i < 3; i++) begin
      issue(rnd256(), 1'b0);
      wait_idle("sweep");
    end

    // start held: one idle cycle between back-to-back sequences
    key = rnd256();
    begin
      logic [255:0] lk;
      push_seq(key, 1'b0, lk);
      push_seq(key, 1'b0, lk);
      kif.last_key = lk;
    end
    d0 = done_cnt;
    idle_cnt = 0;
    kif.start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (!kif.busy) idle_cnt++;
    end
    kif.start = 1'b0;
    wait_idle("hold");
    chk("hold_idle_gap", 128'(idle_cnt), 128'd1);
    chk("hold_seq_count", 128'(done_cnt - d0), 128'd2);

    // reset mid-sequence
    issue(rnd256(), 1'b0);
    wait_round(4'd7, "r7");
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_subkey", kif.subkey, 128'd0);
    chk("mid_rst_round", 128'(kif.round), 128'd0);
    chk("mid_rst_valid", 128'(kif.subkey_valid), 128'd0);
    chk("mid_rst_busy", 128'(kif.busy), 128'd0);
    chk("mid_rst_done", 128'(kif.done), 128'd0);
    exp_q.delete();
    reset = 1'b0;
    @(posedge clk); #1;
    issue(rnd256(), 1'b0);
    wait_idle("post_rst");

    // last_key changes while busy must not disturb the sequence
    issue(rnd256(), 1'b0);
    repeat (5) @(posedge clk);
    #1;
    kif.last_key = rnd256();
    kif.start    = 1'b0;
    wait_idle("key_change");

`ifdef AES_KEYREV_STALL_EN
    issue(rnd256(), 1'b0);
    wait_round(4'd10, "stall10");
    ready_drv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stall_round", 128'(kif.round), 128'd10);
      chk("stall_subkey", kif.subkey, exp_q[0].k);
      chk("stall_valid", 128'(kif.subkey_valid), 128'd1);
    end
    ready_drv = 1'b1;
    wait_round(4'd0, "stall0");
    ready_drv = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("stall_done_held", 128'(kif.done), 128'd1);
      chk("stall_round0", 128'(kif.round), 128'd0);
    end
    ready_drv = 1'b1;
    wait_idle("stall");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
